// File: rtl/shift_ctrl.sv
// shift_ctrl: control front-end for the LED shift stage.
// Synchronizes and debounces two raw pushbuttons. A btn_dir press toggles
// the shift direction (sel), and a btn_run press toggles between PAUSE and
// RUN. While in RUN, a one-cycle step pulse is emitted every TICK_DIV cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level (>= 1)
//   TICK_DIV         clock cycles per step pulse (>= 2)
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   btn_dir  raw direction pushbutton (1 = pressed)
//   btn_run  raw run/pause pushbutton (1 = pressed)
//   sel      registered shift direction
//   step     registered one-cycle advance pulse
//   running  registered, 1 while in RUN
module shift_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir,
  input  logic btn_run,
  output logic sel,
  output logic step,
  output logic running
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DB_ONE   = CW'(1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Bit 0 carries btn_dir, bit 1 carries btn_run.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  state_t        state;
  logic [PW-1:0] presc;

  // Synchronizer + debounce. The press pulse is registered on the same edge
  // the stable level rises, so the action lands one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= {btn_run, btn_dir};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Run/pause FSM with prescaler and registered outputs. A run press takes
  // priority over the terminal count, so pausing on the terminal cycle
  // suppresses that step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= PAUSE;
      presc   <= '0;
      sel     <= 1'b0;
      step    <= 1'b0;
      running <= 1'b0;
    end else begin
      step <= 1'b0;
      if (press[0]) begin
        sel <= ~sel;
      end
      if (press[1]) begin
        presc <= '0;
        if (state == PAUSE) begin
          state   <= RUN;
          running <= 1'b1;
        end else begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else if (state == RUN) begin
        if (presc == PRE_LAST) begin
          presc <= '0;
          step  <= 1'b1;
        end else begin
          presc <= presc + PRE_ONE;
        end
      end else begin
        presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Testbench for shift_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8.
// Stimulus pushes expected output snapshots (by cycle) and expected step
// cycles into queues; an independent monitor compares on each falling edge.
module tb_shift_ctrl;

  logic clk;
  logic reset;
  logic btn_dir;
  logic btn_run;
  logic sel;
  logic step;
  logic running;

  shift_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_dir(btn_dir),
    .btn_run(btn_run),
    .sel(sel),
    .step(step),
    .running(running)
  );

  typedef struct {
    int   cyc;
    logic sel;
    logic running;
  } snap_t;

  snap_t exp_q[$];
  int    step_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    steps_seen = 0;
  snap_t e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares snapshots due this cycle and accounts for every step.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL snap_missed: checked at cyc %0d, required cyc %0d", cyc, e.cyc);
      end else if (sel !== e.sel || running !== e.running) begin
        n_fail++;
        $display("FAIL snap cyc %0d: sel=%b running=%b, required sel=%b running=%b",
                 cyc, sel, running, e.sel, e.running);
      end
    end
    while (step_q.size() > 0 && step_q[0] < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL step_missing: no step at cyc %0d (now cyc %0d)", step_q[0], cyc);
      void'(step_q.pop_front());
    end
    if (step === 1'b1) begin
      steps_seen++;
      n_checks++;
      if (step_q.size() > 0 && step_q[0] == cyc) begin
        void'(step_q.pop_front());
      end else begin
        n_fail++;
        $display("FAIL step_unexpected: step=1 at cyc %0d, required 0", cyc);
      end
    end else if (step !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL step_x: step=%b at cyc %0d, required 0/1", step, cyc);
    end
  end

  task automatic push_snap(input int c, input logic s, input logic r);
    snap_t x;
    x.cyc = c;
    x.sel = s;
    x.running = r;
    exp_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t;
    int p;
    int q;
    reset   = 1'b0;
    btn_dir = 1'b0;
    btn_run = 1'b0;

    // Reset values and idle quiet period.
    tick(3);
    reset = 1'b1;
    t = cyc;
    push_snap(t + 1, 1'b0, 1'b0);
    push_snap(t + 50, 1'b0, 1'b0);
    tick(50);

    // Direction press: sel toggles 6 edges after the first sampling edge.
    t = cyc;
    btn_dir = 1'b1;
    push_snap(t + 6, 1'b0, 1'b0);
    push_snap(t + 7, 1'b1, 1'b0);
    tick(20);
    btn_dir = 1'b0;
    tick(10);
    t = cyc;
    btn_dir = 1'b1;
    push_snap(t + 6, 1'b1, 1'b0);
    push_snap(t + 7, 1'b0, 1'b0);
    tick(10);
    btn_dir = 1'b0;
    tick(10);

    // Bounce rejection: 2-cycle pulses never reach the debounce count.
    btn_run = 1'b1; tick(2);
    btn_run = 1'b0; tick(2);
    btn_run = 1'b1; tick(2);
    btn_run = 1'b0;
    push_snap(cyc + 1, 1'b0, 1'b0);
    tick(4);

    // Held run press: running at edge 6, then 5 steps every 8 cycles.
    t = cyc;
    btn_run = 1'b1;
    push_snap(t + 6, 1'b0, 1'b0);
    push_snap(t + 7, 1'b0, 1'b1);
    p = t + 7;
    for (int j = 1; j <= 5; j++) step_q.push_back(p + 8 * j);
    tick(10);
    btn_run = 1'b0;

    // Pause press lands exactly on the terminal-count cycle (p+48).
    while (cyc < p + 41) @(negedge clk);
    btn_run = 1'b1;
    push_snap(p + 47, 1'b0, 1'b1);
    push_snap(p + 48, 1'b0, 1'b0);
    tick(10);
    btn_run = 1'b0;
    tick(9);

    // Re-enter RUN; first step 8 cycles after running rises.
    q = cyc;
    btn_run = 1'b1;
    push_snap(q + 7, 1'b0, 1'b1);
    step_q.push_back(q + 15);
    step_q.push_back(q + 23);
    tick(10);
    btn_run = 1'b0;
    tick(2);

    // Direction press while running, so sel=1 before the reset.
    btn_dir = 1'b1;
    push_snap(q + 18, 1'b0, 1'b1);
    push_snap(q + 19, 1'b1, 1'b1);
    tick(10);
    btn_dir = 1'b0;

    // Async reset 2 ns after the edge that launches the q+31 step.
    while (cyc < q + 30) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    push_snap(q + 31, 1'b0, 1'b0);
    tick(2);
    reset = 1'b1;
    push_snap(q + 33, 1'b0, 1'b0);
    push_snap(q + 62, 1'b0, 1'b0);
    tick(32);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL snap_queue_drained: %0d left, required 0", exp_q.size());
    end
    n_checks++;
    if (step_q.size() != 0) begin
      n_fail++;
      $display("FAIL step_queue_drained: %0d left, required 0", step_q.size());
    end
    n_checks++;
    if (steps_seen != 7) begin
      n_fail++;
      $display("FAIL step_total: saw %0d, required 7", steps_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
